// File: rtl/demux_1_to_3_reg_if.sv
// Bus bundle for the registered 1-to-3 demultiplexer: one producer port with
// one-hot select, plus three valid/ready destination channels.
interface demux_1_to_3_reg_if #(
    parameter int WORD_LENGTH     = 8,
    parameter int ERR_COUNT_WIDTH = 8
);
    logic [WORD_LENGTH-1:0]     in;
    logic                       in_valid;
    logic                       in_ready;
    logic                       sel_first;
    logic                       sel_second;
    logic                       sel_third;
    logic [WORD_LENGTH-1:0]     first;
    logic                       first_valid;
    logic                       first_ready;
    logic [WORD_LENGTH-1:0]     second;
    logic                       second_valid;
    logic                       second_ready;
    logic [WORD_LENGTH-1:0]     third;
    logic                       third_valid;
    logic                       third_ready;
    logic                       sel_error;
    logic [ERR_COUNT_WIDTH-1:0] err_count;

    // Producer and consumers drive this side.
    modport master (
        output in, in_valid, sel_first, sel_second, sel_third,
               first_ready, second_ready, third_ready,
        input  in_ready, first, first_valid, second, second_valid,
               third, third_valid, sel_error, err_count
    );

    // The demultiplexer itself.
    modport slave (
        input  in, in_valid, sel_first, sel_second, sel_third,
               first_ready, second_ready, third_ready,
        output in_ready, first, first_valid, second, second_valid,
               third, third_valid, sel_error, err_count
    );
endinterface

// File: rtl/demux_1_to_3_reg.sv
// Registered 1-to-3 demultiplexer: a one-hot select steers each accepted word
// into one of three single-entry valid/ready output registers.
module demux_1_to_3_reg #(
    parameter int WORD_LENGTH     = 8,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux_1_to_3_reg_if.slave   bus
);

    function automatic logic is_one_hot3(input logic [2:0] v);
        case (v)
            3'b001, 3'b010, 3'b100: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    logic [2:0]                 sel_s;
    logic [2:0]                 ready_s;
    logic [2:0]                 free_s;
    logic                       sel_ok_s;
    logic                       in_ready_s;
    logic                       accept_s;
    logic [WORD_LENGTH-1:0]     data_r [3];
    logic [2:0]                 valid_r;
    logic                       sel_error_r;
    logic [ERR_COUNT_WIDTH-1:0] err_count_r;

    assign sel_s   = {bus.sel_third, bus.sel_second, bus.sel_first};
    assign ready_s = {bus.third_ready, bus.second_ready, bus.first_ready};
    assign free_s  = ~valid_r | ready_s;

    // Select decode and input handshake; bad selects are always consumed.
    always_comb begin
        sel_ok_s   = is_one_hot3(sel_s);
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (sel_ok_s) begin
            in_ready_s = |(sel_s & free_s);
        end else begin
            in_ready_s = 1'b1;
        end
        accept_s = bus.in_valid && in_ready_s;
    end

    // Channel registers: load on a routed accept, otherwise drain on delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                data_r[k]  <= {WORD_LENGTH{1'b0}};
                valid_r[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (accept_s && sel_ok_s && sel_s[k]) begin
                    data_r[k]  <= bus.in;
                    valid_r[k] <= 1'b1;
                end else if (valid_r[k] && ready_s[k]) begin
                    valid_r[k] <= 1'b0;
                end else begin
                    valid_r[k] <= valid_r[k];
                end
            end
        end
    end

    // Dropped-word pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_error_r <= 1'b0;
            err_count_r <= {ERR_COUNT_WIDTH{1'b0}};
        end else begin
            sel_error_r <= accept_s && !sel_ok_s;
            if (accept_s && !sel_ok_s && (err_count_r != {ERR_COUNT_WIDTH{1'b1}})) begin
                err_count_r <= err_count_r + {{(ERR_COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.first        = data_r[0];
    assign bus.second       = data_r[1];
    assign bus.third        = data_r[2];
    assign bus.first_valid  = valid_r[0];
    assign bus.second_valid = valid_r[1];
    assign bus.third_valid  = valid_r[2];
    assign bus.sel_error    = sel_error_r;
    assign bus.err_count    = err_count_r;

endmodule

// File: doc/demux_1_to_3_reg.md
Name: demux_1_to_3_reg

Overview:
- Registered 1-to-3 demultiplexer, the distributing counterpart of the datapath's one-hot-select 3-to-1 muxes. One producer word is steered by a one-hot select to one of three destination channels.
- Each destination channel is a single-entry output register with a valid/ready handshake.
- Sits between a shared source (ALU result / memory read bus) and three consumers (register-file write port, memory write-data path, PC/address path).

Parameters:
WORD_LENGTH, 8, width of the data word on input and all three outputs
ERR_COUNT_WIDTH, 8, width of the saturating select-error counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in  input  WORD_LENGTH  input data word
in_valid  input  1  input word presented this cycle
in_ready  output  1  block accepts the input word this cycle
sel_first  input  1  one-hot select: route to channel first
sel_second  input  1  one-hot select: route to channel second
sel_third  input  1  one-hot select: route to channel third
first  output  WORD_LENGTH  channel first data register
first_valid  output  1  channel first holds an undelivered word
first_ready  input  1  consumer of first accepts this cycle
second  output  WORD_LENGTH  channel second data register
second_valid  output  1  channel second valid
second_ready  input  1  consumer of second accepts
third  output  WORD_LENGTH  channel third data register
third_valid  output  1  channel third valid
third_ready  input  1  consumer of third accepts
sel_error  output  1  one-cycle pulse: a word was dropped for a bad select
err_count  output  ERR_COUNT_WIDTH  saturating count of dropped words

Behaviour:
- Reset (rst=1 at clock edge): first/second/third=0; all *_valid=0; sel_error=0; err_count=0. While rst=1, in_ready=0 and no transfer is accepted.
- Select decode (combinational, sampled only when in_valid=1):
  - sel_ok = exactly one of sel_first/second/third high.
  - Selected channel k is free when !k_valid || k_ready.
- in_ready (combinational, rst=0):
  - sel_ok: in_ready = free(k).
  - !sel_ok: in_ready = 1; the word is consumed and dropped.
  - in_ready has no dependence on unselected channels.
- Accept = in_valid && in_ready.
- Per channel k, priority at each edge:
  - Accept with sel_ok targeting k: k <= in, k_valid <= 1. If k_ready was also high, the old word is delivered and the new one loaded in the same cycle, so valid stays 1.
  - Else if k_valid && k_ready: k_valid <= 0. Data register holds its last value, matching the hold-on-no-select convention of the muxes.
  - Else: hold data and valid.
- Latency: 1 cycle from accept to k_valid=1. Throughput: 1 word/cycle per channel when its ready stays high.
- Bad select (accept with !sel_ok, zero or multiple selects high):
  - No channel changes.
  - sel_error <= 1 for exactly the next cycle.
  - err_count <= err_count+1, saturating at 2^ERR_COUNT_WIDTH-1 (no wrap).
- sel_error <= 0 on every other edge.
- in_valid=0: selects are ignored; no error is flagged regardless of select values.
- Word ordering within a channel is preserved. There is no ordering guarantee across channels.
- Reset mid-operation: pending valid words are discarded without delivery; counters clear; the first accept is possible on the cycle after rst falls.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> all outputs 0, all *_valid=0, err_count=0, in_ready=0 during reset and 1 afterwards.
- Single route: in=8'hA5, sel_second=1, in_valid=1 for 1 cycle, second_ready=0 -> next cycle second=8'hA5, second_valid=1, others invalid. With second_ready=1, second_valid drops the following cycle and second stays 8'hA5.
- Backpressure: second_valid=1, second_ready=0, new word 8'h3C to second -> in_ready=0 and no change. Same cycle, a word 8'h11 to first is not accepted (single input port). Raise second_ready -> in_ready=1, second=8'h3C next cycle with valid held at 1.
- Streaming: 4 words 1,2,3,4 to third with third_ready=1 every cycle -> accepted on 4 consecutive cycles, third shows 1,2,3,4 on consecutive cycles, third_valid continuously high.
- Bad select: in_valid=1 with sel_first=sel_third=1, then with no select, then with a valid select -> two single-cycle sel_error pulses, err_count=2, no channel updated by the bad words. Drive 300 bad words with ERR_COUNT_WIDTH=8 -> err_count saturates at 255.
- Reset mid-operation: first_valid=1 and third_valid=1 pending, assert rst for 1 cycle -> both valid=0, data=0, err_count=0. Word sent to first on the cycle after reset appears 1 cycle later.
